// File: rtl/dm_arbiter_if.sv
// Bus bundle between the two DM masters, the arbiter and the 32x8 data memory.
// The master modport is the requester/memory side; the slave modport is the arbiter.
interface dm_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;

    logic              dm_memWrite;
    logic              dm_memRead;
    logic [ADDR_W-1:0] dm_address;
    logic [DATA_W-1:0] dm_data_in;
    logic [DATA_W-1:0] dm_data_out;

    logic              busy;

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_rdata,
        input  dm_memWrite, dm_memRead, dm_address, dm_data_in,
        output dm_data_out,
        input  busy
    );

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_rdata,
        output dm_memWrite, dm_memRead, dm_address, dm_data_in,
        input  dm_data_out,
        output busy
    );
endinterface

// File: rtl/dm_arbiter.sv
// Two-master arbiter/sequencer for the single DM port: IDLE -> ACCESS -> DONE per transaction.
// Define DM_ARB_FIXED_PRI_EN for fixed priority (m0 first); default is round-robin.
module dm_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    dm_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              winner_q, winner_d;
    logic              m0_ack_q, m0_ack_d;
    logic              m1_ack_q, m1_ack_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_read_q, mem_read_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic              busy_q, busy_d;
    logic              pick_m1;
    logic              sel_we;

    // last_grant resets to m1 so that m0 wins the first simultaneous request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            winner_q     <= 1'b0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            address_q    <= '0;
            data_in_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            mem_write_q  <= mem_write_d;
            mem_read_q   <= mem_read_d;
            address_q    <= address_d;
            data_in_q    <= data_in_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
`ifdef DM_ARB_FIXED_PRI_EN
        pick_m1 = bus.m1_req && !bus.m0_req;
`else
        pick_m1 = bus.m1_req && (!bus.m0_req || !last_grant_q);
`endif
        sel_we = pick_m1 ? bus.m1_we : bus.m0_we;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        mem_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        address_d    = address_q;
        data_in_d    = data_in_q;

        case (state_q)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    winner_d    = pick_m1;
                    address_d   = pick_m1 ? bus.m1_addr : bus.m0_addr;
                    data_in_d   = pick_m1 ? bus.m1_wdata : bus.m0_wdata;
                    mem_write_d = sel_we;
                    mem_read_d  = !sel_we;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_read_q) begin
                    if (winner_q) m1_rdata_d = bus.dm_data_out;
                    else          m0_rdata_d = bus.dm_data_out;
                end
                if (winner_q) m1_ack_d = 1'b1;
                else          m0_ack_d = 1'b1;
                last_grant_d = winner_q;
                state_d      = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.m0_ack      = m0_ack_q;
    assign bus.m1_ack      = m1_ack_q;
    assign bus.m0_rdata    = m0_rdata_q;
    assign bus.m1_rdata    = m1_rdata_q;
    assign bus.dm_memWrite = mem_write_q;
    assign bus.dm_memRead  = mem_read_q;
    assign bus.dm_address  = address_q;
    assign bus.dm_data_in  = data_in_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Testbench for dm_arbiter: directed vector table, reset-in-ACCESS sequence, and
// randomized traffic checked against a transaction-level model of the arbiter.
module tb_dm_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    dm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural DM: combinational read, write on the rising edge
    logic [DATA_W-1:0] dm_mem [32];
    assign bus.dm_data_out = dm_mem[bus.dm_address];
    always @(posedge clk) begin
        if (bus.dm_memWrite) dm_mem[bus.dm_address] <= bus.dm_data_in;
    end

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] ref_mem [32];
    bit                ref_last;
    logic [DATA_W-1:0] ref_rd [2];

    typedef struct {
        bit         rst;
        bit         r0;
        bit         we0;
        logic [4:0] a0;
        logic [7:0] d0;
        bit         r1;
        bit         we1;
        logic [4:0] a1;
        logic [7:0] d1;
        int         g_rr;
        int         rd_rr;
        int         g_fp;
        int         rd_fp;
    } vec_t;

    vec_t tbl [9];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        ref_last  = 1'b1;
        ref_rd[0] = '0;
        ref_rd[1] = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_busy"},  bus.busy,        0);
        check_output({tag, "_ack0"},  bus.m0_ack,      0);
        check_output({tag, "_ack1"},  bus.m1_ack,      0);
        check_output({tag, "_mw"},    bus.dm_memWrite, 0);
        check_output({tag, "_mr"},    bus.dm_memRead,  0);
        check_output({tag, "_addr"},  bus.dm_address,  0);
        check_output({tag, "_din"},   bus.dm_data_in,  0);
        check_output({tag, "_rd0"},   bus.m0_rdata,    0);
        check_output({tag, "_rd1"},   bus.m1_rdata,    0);
    endtask

    task automatic do_reset();
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        model_reset();
    endtask

    // Called at a negedge with the arbiter in IDLE; returns after DONE (or one idle cycle)
    task automatic apply_stimulus(input bit r0, input bit we0, input logic [4:0] a0, input logic [7:0] d0,
                                  input bit r1, input bit we1, input logic [4:0] a1, input logic [7:0] d1,
                                  output int granted);
        int         w;
        bit         we_w;
        logic [4:0] a_w;
        logic [7:0] d_w;
        bus.m0_req = r0; bus.m0_we = we0; bus.m0_addr = a0; bus.m0_wdata = d0;
        bus.m1_req = r1; bus.m1_we = we1; bus.m1_addr = a1; bus.m1_wdata = d1;
        if (r0 && r1) begin
`ifdef DM_ARB_FIXED_PRI_EN
            w = 0;
`else
            w = ref_last ? 0 : 1;
`endif
        end else if (r0) w = 0;
        else if (r1) w = 1;
        else w = -1;

        @(negedge clk);
        if (w < 0) begin
            check_output("idle_busy", bus.busy, 0);
            check_output("idle_mw",   bus.dm_memWrite, 0);
            check_output("idle_mr",   bus.dm_memRead, 0);
            check_output("idle_acks", {bus.m0_ack, bus.m1_ack}, 0);
            granted = -1;
            return;
        end
        we_w = (w == 1) ? we1 : we0;
        a_w  = (w == 1) ? a1  : a0;
        d_w  = (w == 1) ? d1  : d0;
        check_output("acc_busy", bus.busy, 1);
        check_output("acc_mw",   bus.dm_memWrite, we_w);
        check_output("acc_mr",   bus.dm_memRead, !we_w);
        check_output("acc_addr", bus.dm_address, a_w);
        check_output("acc_din",  bus.dm_data_in, d_w);
        check_output("acc_acks", {bus.m0_ack, bus.m1_ack}, 0);

        if (we_w) ref_mem[a_w] = d_w;
        else      ref_rd[w]    = ref_mem[a_w];
        ref_last = w[0];

        @(negedge clk);
        granted = bus.m0_ack ? 0 : (bus.m1_ack ? 1 : -1);
        check_output("done_strobes", {bus.dm_memWrite, bus.dm_memRead}, 0);
        check_output("done_ack0", bus.m0_ack, (w == 0));
        check_output("done_ack1", bus.m1_ack, (w == 1));
        check_output("done_rd0",  bus.m0_rdata, ref_rd[0]);
        check_output("done_rd1",  bus.m1_rdata, ref_rd[1]);
        check_output("done_addr", bus.dm_address, a_w);
        check_output("done_busy", bus.busy, 1);

        @(negedge clk);
        check_output("post_acks", {bus.m0_ack, bus.m1_ack}, 0);
        check_output("post_busy", bus.busy, 0);
        check_output("post_rd0",  bus.m0_rdata, ref_rd[0]);
        check_output("post_rd1",  bus.m1_rdata, ref_rd[1]);
    endtask

    initial begin
        int         g;
        int         exp_g;
        int         exp_rd;
        bit         pr [2];
        bit         pwe [2];
        logic [4:0] pa [2];
        logic [7:0] pd [2];

        for (int i = 0; i < 32; i++) begin
            dm_mem[i]  = '0;
            ref_mem[i] = '0;
        end
        bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0;

        //          rst r0 we0 a0     d0     r1 we1 a1     d1     g_rr rd_rr  g_fp rd_fp
        tbl[0] = '{0,  1, 1, 5'h03, 8'hA5, 0, 0, 5'h00, 8'h00,  0,  -1,     0,  -1};
        tbl[1] = '{0,  1, 0, 5'h03, 8'h00, 0, 0, 5'h00, 8'h00,  0,  'hA5,   0,  'hA5};
        tbl[2] = '{1,  1, 1, 5'h01, 8'h11, 1, 1, 5'h02, 8'h22,  0,  -1,     0,  -1};
        tbl[3] = '{0,  1, 1, 5'h04, 8'h44, 1, 1, 5'h02, 8'h22,  1,  -1,     0,  -1};
        tbl[4] = '{0,  1, 1, 5'h04, 8'h44, 1, 1, 5'h05, 8'h55,  0,  -1,     0,  -1};
        tbl[5] = '{0,  1, 1, 5'h06, 8'h66, 1, 1, 5'h05, 8'h55,  1,  -1,     0,  -1};
        tbl[6] = '{0,  1, 0, 5'h04, 8'h00, 1, 0, 5'h02, 8'h00,  0,  'h44,   0,  'h44};
        tbl[7] = '{0,  1, 0, 5'h04, 8'h00, 1, 0, 5'h02, 8'h00,  1,  'h22,   0,  'h44};
        tbl[8] = '{0,  0, 0, 5'h00, 8'h00, 0, 0, 5'h00, 8'h00, -1,  -1,    -1,  -1};

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].rst) do_reset();
            apply_stimulus(tbl[i].r0, tbl[i].we0, tbl[i].a0, tbl[i].d0,
                           tbl[i].r1, tbl[i].we1, tbl[i].a1, tbl[i].d1, g);
`ifdef DM_ARB_FIXED_PRI_EN
            exp_g  = tbl[i].g_fp;
            exp_rd = tbl[i].rd_fp;
`else
            exp_g  = tbl[i].g_rr;
            exp_rd = tbl[i].rd_rr;
`endif
            check_output($sformatf("tbl%0d_grant", i), g, exp_g);
            if (exp_rd >= 0) begin
                check_output($sformatf("tbl%0d_rdata", i), (g == 1) ? bus.m1_rdata : bus.m0_rdata, exp_rd);
            end
        end

        // Reset in the middle of an m1 write: strobe and busy must drop asynchronously
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 5'h03; bus.m1_wdata = 8'hA5;
        @(negedge clk);
        check_output("rst_pre_mw", bus.dm_memWrite, 1);
        #1 rst_n = 1'b0;
        #1;
        check_output("rst_async_mw",   bus.dm_memWrite, 0);
        check_output("rst_async_busy", bus.busy, 0);
        check_output("rst_async_rd0",  bus.m0_rdata, 0);
        check_output("rst_async_rd1",  bus.m1_rdata, 0);
        bus.m1_req = 1'b0;
        @(negedge clk);
        check_output("rst_no_ack1", bus.m1_ack, 0);
        check_output("rst_idle",    bus.busy, 0);
        rst_n = 1'b1;
        model_reset();
        apply_stimulus(1, 0, 5'h03, 8'h00, 1, 0, 5'h03, 8'h00, g);
        check_output("rst_m0_first", g, 0);

`ifdef DM_ARB_FIXED_PRI_EN
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1, 1, 5'(10 + i), 8'(i), 1, 1, 5'h14, 8'h77, g);
            check_output($sformatf("fp_m0_grant%0d", i), g, 0);
        end
        apply_stimulus(0, 0, 5'h00, 8'h00, 1, 1, 5'h14, 8'h77, g);
        check_output("fp_m1_after_drop", g, 1);
`endif

        for (int m = 0; m < 2; m++) pr[m] = 1'b0;
        for (int s = 0; s < 80; s++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pr[m] && $urandom_range(0, 3) != 0) begin
                    pr[m]  = 1'b1;
                    pwe[m] = 1'($urandom_range(0, 1));
                    pa[m]  = 5'($urandom_range(0, 31));
                    pd[m]  = 8'($urandom);
                end
            end
            apply_stimulus(pr[0], pwe[0], pa[0], pd[0], pr[1], pwe[1], pa[1], pd[1], g);
            if (g >= 0) pr[g] = 1'b0;
        end

        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
